// File: rtl/riscv_pe_mul_pkg.sv
// Shared definitions for the RISC-V multiply unit: op encodings, the
// signedness class of each op, and the product correction/selection helpers.
package riscv_pe_mul_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  // Signedness of (rs1, rs2) as the op interprets them
  typedef enum logic [1:0] {
    CLS_SS = 2'b00,
    CLS_SU = 2'b01,
    CLS_UU = 2'b10
  } mul_cls_e;

  // MUL only uses the low half, which is class-independent, so it maps to SS
  function automatic mul_cls_e op_class(input logic [1:0] op);
    mul_cls_e cls;
    case (op)
      OP_MULHSU: cls = CLS_SU;
      OP_MULHU:  cls = CLS_UU;
      default:   cls = CLS_SS;
    endcase
    return cls;
  endfunction

  // Turn the signed x signed product into the product for the op's class.
  // Reinterpreting a negative operand as unsigned adds 2^32 to it, which
  // contributes (other operand << 32) to the product (mod 2^64).
  function automatic logic [2*XLEN-1:0] correct_product(
    input logic [2*XLEN-1:0] p,
    input logic [XLEN-1:0]   rs1,
    input logic [XLEN-1:0]   rs2,
    input mul_cls_e          cls
  );
    logic [2*XLEN-1:0] c;
    c = p;
    case (cls)
      CLS_SU: begin
        if (rs2[XLEN-1]) c = c + {rs1, 32'd0};
        else             c = c;
      end
      CLS_UU: begin
        if (rs1[XLEN-1]) c = c + {rs2, 32'd0};
        else             c = c;
        if (rs2[XLEN-1]) c = c + {rs1, 32'd0};
        else             c = c;
      end
      default: c = p;
    endcase
    return c;
  endfunction

  // Low half for MUL, high half for the MULH* family
  function automatic logic [XLEN-1:0] select_half(
    input logic [1:0]        op,
    input logic [2*XLEN-1:0] prod
  );
    return (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

endpackage

// File: rtl/booth_wallace_multiplier.sv
// 32x32 signed multiplier producing the full 64-bit product.
// Radix-4 Booth recoding of b into 16 signed digits; partial products are
// accumulated combinationally (the synthesis tool builds the reduction tree).
module booth_wallace_multiplier (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] p_o
);

  logic [32:0] b_ext_s;
  logic [63:0] a_ext_s;
  logic [2:0]  sel_s;
  logic [63:0] pp_s;
  logic [63:0] acc_s;

  assign b_ext_s = {b_i, 1'b0};
  assign a_ext_s = {{32{a_i[31]}}, a_i};

  // Booth digit selection and partial-product accumulation
  always_comb begin
    acc_s = 64'd0;
    sel_s = 3'b000;
    pp_s  = 64'd0;
    for (int i = 0; i < 16; i++) begin
      sel_s = b_ext_s[2*i +: 3];
      case (sel_s)
        3'b001, 3'b010: pp_s = a_ext_s;
        3'b011:         pp_s = a_ext_s << 1;
        3'b100:         pp_s = -(a_ext_s << 1);
        3'b101, 3'b110: pp_s = -a_ext_s;
        default:        pp_s = 64'd0;
      endcase
      acc_s = acc_s + (pp_s << (2*i));
    end
  end

  assign p_o = acc_s;

endmodule

// File: rtl/rv_mul_unit.sv
// RV32M multiply unit: two-stage valid/ready pipeline (S1 operands, S2 result)
// with the multiplier between the stages.
// Optional feature macro MUL_RESULT_REUSE_EN: one-entry result cache; a hit
// accepted while S1 is empty is loaded straight into S2 (1-cycle latency).
module rv_mul_unit
  import riscv_pe_mul_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_valid_q;
  logic [1:0]       s1_op_q;
  logic [31:0]      s1_rs1_q;
  logic [31:0]      s1_rs2_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q;
  logic [31:0]      s2_result_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic [31:0]      s2_result_d;
  logic [TAG_W-1:0] s2_tag_d;

  logic             s2_adv_s;
  logic             accept_s;
  logic [63:0]      prod_raw_s;
  logic [63:0]      prod_cor_s;
  logic [31:0]      s1_result_s;
  logic             bypass_s;
  logic [31:0]      byp_result_s;

  assign s2_adv_s = !s2_valid_q || out_ready;
  assign in_ready = rst_n && !flush && (!s1_valid_q || s2_adv_s);
  assign accept_s = in_valid && in_ready;

  booth_wallace_multiplier u_mult (
    .a_i (s1_rs1_q),
    .b_i (s1_rs2_q),
    .p_o (prod_raw_s)
  );

  assign prod_cor_s  = correct_product(prod_raw_s, s1_rs1_q, s1_rs2_q, op_class(s1_op_q));
  assign s1_result_s = select_half(s1_op_q, prod_cor_s);

`ifdef MUL_RESULT_REUSE_EN
  logic        cache_valid_q;
  logic [31:0] cache_rs1_q;
  logic [31:0] cache_rs2_q;
  mul_cls_e    cache_cls_q;
  logic [63:0] cache_prod_q;
  logic        hit_s;

  assign hit_s = cache_valid_q && (in_rs1 == cache_rs1_q) && (in_rs2 == cache_rs2_q) &&
                 ((in_op == OP_MUL) || (op_class(in_op) == cache_cls_q));
  // Bypass only when S1 is empty, so the result cannot overtake an older op
  assign bypass_s     = accept_s && hit_s && !s1_valid_q && s2_adv_s;
  assign byp_result_s = select_half(in_op, cache_prod_q);

  // Capture the corrected product of every op leaving S1; kill on flush/reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cache_valid_q <= 1'b0;
    end else if (flush) begin
      cache_valid_q <= 1'b0;
    end else if (s2_adv_s && s1_valid_q) begin
      cache_valid_q <= 1'b1;
      cache_rs1_q   <= s1_rs1_q;
      cache_rs2_q   <= s1_rs2_q;
      cache_cls_q   <= op_class(s1_op_q);
      cache_prod_q  <= prod_cor_s;
    end
  end
`else
  assign bypass_s     = 1'b0;
  assign byp_result_s = 32'd0;
`endif

  // S1 operand stage: loads on accept unless the request bypasses to S2
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
    end else if (!s1_valid_q || s2_adv_s) begin
      s1_valid_q <= accept_s && !bypass_s;
      if (accept_s) begin
        s1_op_q  <= in_op;
        s1_rs1_q <= in_rs1;
        s1_rs2_q <= in_rs2;
        s1_tag_q <= in_tag;
      end
    end
  end

  // S2 input mux: S1 result normally, cached result on a bypass
  always_comb begin
    s2_result_d = s2_result_q;
    s2_tag_d    = s2_tag_q;
    if (s1_valid_q) begin
      s2_result_d = s1_result_s;
      s2_tag_d    = s1_tag_q;
    end else if (bypass_s) begin
      s2_result_d = byp_result_s;
      s2_tag_d    = in_tag;
    end else begin
      s2_result_d = s2_result_q;
      s2_tag_d    = s2_tag_q;
    end
  end

  // S2 result stage: holds its contents while stalled by out_ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_result_q <= 32'd0;
      s2_tag_q    <= '0;
    end else if (flush) begin
      s2_valid_q <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_q  <= s1_valid_q || bypass_s;
      s2_result_q <= s2_result_d;
      s2_tag_q    <= s2_tag_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_tag    = s2_tag_q;

endmodule

// File: tb/tb_rv_mul_unit.sv
// Self-checking bench for rv_mul_unit: directed vector table, backpressure,
// flush/reset and reuse sequences, then randomized traffic against a model.
module tb_rv_mul_unit;

  localparam int TAG_W = 5;
`ifdef MUL_RESULT_REUSE_EN
  localparam int EXP_REUSE_LAT = 1;
`else
  localparam int EXP_REUSE_LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_rs1, in_rs2, out_result;
  logic [TAG_W-1:0] in_tag, out_tag;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct { logic [31:0] res; logic [TAG_W-1:0] tag; } exp_t;
  exp_t sbq[$];

  typedef struct { logic [1:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] exp; } vec_t;
  vec_t tbl[10];

  rv_mul_unit #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Reference: extend each operand to 64 bits per its signedness, multiply mod 2^64
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, y, p;
    x = (op == 2'b11) ? {32'd0, a} : {{32{a[31]}}, a};
    y = (op == 2'b10 || op == 2'b11) ? {32'd0, b} : {{32{b[31]}}, b};
    p = x * y;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock with scoreboarding; entered and left at a falling edge
  task automatic cycle(output bit acc);
    bit f, r;
    exp_t e;
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out", out_valid, 1'b0);
      end else begin
        e = sbq.pop_front();
        chk("sb_result", out_result, e.res);
        chk("sb_tag", out_tag, e.tag);
      end
    end
    acc = in_valid && in_ready;
    if (acc) sbq.push_back('{model(in_op, in_rs1, in_rs2), in_tag});
    f = flush;
    r = rst_n;
    @(posedge clk);
    if (f || !r) sbq.delete();
    @(negedge clk);
  endtask

  // Issue one op alone with out_ready high, measure accept-to-out_valid latency
  task automatic single(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tg, output logic [31:0] res,
                        output logic [TAG_W-1:0] rtag, output int lat);
    int w;
    w = 0;
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tg; out_ready = 1'b1;
    #1;
    while (!in_ready && w < 20) begin @(posedge clk); @(negedge clk); #1; w++; end
    chk("single_accept", in_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    #1;
    while (!out_valid && lat < 10) begin @(posedge clk); @(negedge clk); #1; lat++; end
    res = out_result;
    rtag = out_tag;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res, held;
    logic [TAG_W-1:0] rtag, heldtag;
    int lat, n_acc, guard;
    bit acc, gotc;

    tbl[0] = '{2'b00, 32'd7,          32'd9,          32'd63};
    tbl[1] = '{2'b11, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE};
    tbl[2] = '{2'b01, 32'h80000000,   32'h80000000,   32'h40000000};
    tbl[3] = '{2'b10, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF};
    tbl[4] = '{2'b01, 32'h7FFFFFFF,   32'h7FFFFFFF,   32'h3FFFFFFF};
    tbl[5] = '{2'b11, 32'h80000000,   32'd2,          32'd1};
    tbl[6] = '{2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1};
    tbl[7] = '{2'b10, 32'h80000000,   32'h80000000,   32'hC0000000};
    tbl[8] = '{2'b01, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF};
    tbl[9] = '{2'b00, 32'd0,          32'h12345678,   32'd0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
    in_rs1 = 32'd0; in_rs2 = 32'd0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag", out_tag, 5'd0);
    rst_n = 1'b1; #1;
    chk("ready_after_reset", in_ready, 1'b1);
    @(negedge clk);

    // Directed vectors, each issued alone
    for (int i = 0; i < 10; i++) begin
      single(tbl[i].op, tbl[i].a, tbl[i].b, TAG_W'(i + 3), res, rtag, lat);
      chk("tbl_result", res, tbl[i].exp);
      chk("tbl_tag", rtag, TAG_W'(i + 3));
      chk("tbl_latency", lat, 2);
    end

    // Reuse: MULH then MUL on the same operands after an idle gap
    single(2'b01, 32'hFFFFFFE7, 32'hFFFFFFF3, 5'd20, res, rtag, lat);
    chk("reuse_mulh", res, 32'd0);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    single(2'b00, 32'hFFFFFFE7, 32'hFFFFFFF3, 5'd21, res, rtag, lat);
    chk("reuse_mul", res, 32'd325);
    chk("reuse_tag", rtag, 5'd21);
    chk("reuse_latency", lat, EXP_REUSE_LAT);

    // Backpressure: three back-to-back ops with out_ready low
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'b11; in_rs1 = 32'h12345678; in_rs2 = 32'h9ABCDEF0; in_tag = 5'd1;
    cycle(acc); chk("bp_acc_a", acc, 1'b1);
    in_op = 2'b00; in_rs1 = 32'hDEADBEEF; in_rs2 = 32'h00001234; in_tag = 5'd2;
    cycle(acc); chk("bp_acc_b", acc, 1'b1);
    in_op = 2'b01; in_rs1 = 32'h80000001; in_rs2 = 32'h7FFFFFFF; in_tag = 5'd3;
    #1;
    chk("bp_ready_c", in_ready, 1'b0);
    chk("bp_out_valid", out_valid, 1'b1);
    chk("bp_held_val", out_result, model(2'b11, 32'h12345678, 32'h9ABCDEF0));
    held = out_result; heldtag = out_tag;
    repeat (3) begin
      cycle(acc);
      chk("bp_no_accept", acc, 1'b0);
      chk("bp_stable_res", out_result, held);
      chk("bp_stable_tag", out_tag, heldtag);
    end
    out_ready = 1'b1;
    gotc = 1'b0;
    guard = 0;
    while ((sbq.size() != 0 || in_valid) && guard < 12) begin
      cycle(acc);
      if (acc) begin gotc = 1'b1; in_valid = 1'b0; end
      guard++;
    end
    chk("bp_c_accepted", gotc, 1'b1);
    chk("bp_drained", sbq.size(), 0);

    // Flush with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'b10; in_rs1 = 32'h00000055; in_rs2 = 32'hF0000000; in_tag = 5'd4;
    cycle(acc);
    in_op = 2'b00; in_rs1 = 32'h00000066; in_rs2 = 32'h00000077; in_tag = 5'd5;
    cycle(acc);
    flush = 1'b1; in_op = 2'b01; in_rs1 = 32'h11; in_rs2 = 32'h22; in_tag = 5'd6;
    #1;
    chk("flush_in_ready", in_ready, 1'b0);
    cycle(acc);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    repeat (3) begin cycle(acc); chk("flush_no_stale", out_valid, 1'b0); end

    // Reset for one cycle in the middle of a stream
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_op = 2'(i); in_rs1 = 32'h1000 + 32'(i); in_rs2 = 32'hFFFF0000 - 32'(i); in_tag = TAG_W'(8 + i);
      cycle(acc);
    end
    rst_n = 1'b0;
    cycle(acc);
    rst_n = 1'b1; in_valid = 1'b0;
    chk("rst_mid_out_valid", out_valid, 1'b0);
    repeat (4) begin cycle(acc); chk("rst_no_stale", out_valid, 1'b0); end

    // Randomized traffic with random backpressure
    n_acc = 0;
    guard = 0;
    while (n_acc < 1000 && guard < 20000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_op = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 5))
            0: in_rs1 = 32'h80000000;
            1: in_rs1 = 32'hFFFFFFFF;
            2: in_rs1 = 32'h7FFFFFFF;
            default: in_rs1 = $urandom;
          endcase
          case ($urandom_range(0, 5))
            0: in_rs2 = 32'h80000000;
            1: in_rs2 = 32'hFFFFFFFF;
            2: in_rs2 = 32'd0;
            default: in_rs2 = $urandom;
          endcase
        end
        in_tag = TAG_W'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      cycle(acc);
      if (acc) begin n_acc++; in_valid = 1'b0; end
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (sbq.size() != 0 && guard < 20) begin cycle(acc); guard++; end
    chk("rand_count", n_acc, 1000);
    chk("rand_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_mul_unit.md
RV_MUL_UNIT -- requirements
Module: rv_mul_unit

Interface
REQ-001 The block SHALL have parameter TAG_W, default 5, meaning the width of the destination-register tag carried alongside each operation.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port flush, input, 1 bit: synchronous pipeline kill.
REQ-005 The block SHALL have port in_valid, input, 1 bit: request valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the unit accepts a request this cycle.
REQ-007 The block SHALL have port in_op, input, 2 bits, encoded as 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-008 The block SHALL have ports in_rs1 and in_rs2, input, 32 bits each: the operands.
REQ-009 The block SHALL have port in_tag, input, TAG_W bits: the destination tag.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port out_result, output, 32 bits: the selected product half.
REQ-013 The block SHALL have port out_tag, output, TAG_W bits: the tag of the result.

Function
REQ-014 The block SHALL transfer on a handshake when valid and ready are both high on a clock edge; there SHALL be no combinational path from in_valid to in_ready.
REQ-015 The block SHALL be a two-stage pipeline: S1 registers op, rs1, rs2 and tag; the multiplier sits between S1 and S2; S2 registers the 32-bit result and the tag.
REQ-016 Latency SHALL be 2 cycles from an accepting edge to out_valid high, when no stall occurs.
REQ-017 S2 SHALL advance when (!s2_valid || out_ready); S1 SHALL advance into S2 under that same condition.
REQ-018 in_ready SHALL equal (!s1_valid || S2 advance); with out_ready held high, throughput SHALL be 1 operation per cycle.
REQ-019 Under backpressure the block SHALL hold out_result and out_tag stable while out_valid is high and out_ready is low.
REQ-020 The multiplier SHALL produce P = signed(rs1) × signed(rs2), 64 bits.
REQ-021 The 64-bit product SHALL be corrected by signedness class, with all sums taken mod 2^64:
- MULH: no correction.
- MULHSU: P + (rs2[31] ? rs1<<32 : 0).
- MULHU: P + (rs1[31] ? rs2<<32 : 0) + (rs2[31] ? rs1<<32 : 0).
REQ-022 The selected output SHALL be bits [31:0] of P for MUL and bits [63:32] of the corrected product for the other three ops.
REQ-023 flush SHALL clear s1_valid and s2_valid at the next edge and SHALL override any simultaneous accept; in_ready SHALL be forced low during the flush cycle.
REQ-024 The block SHALL drop nothing and duplicate nothing: results SHALL leave in acceptance order.

Reset
REQ-025 While rst_n is low at a clock edge, the block SHALL set s1_valid=0, s2_valid=0, out_valid=0, out_result=0 and out_tag=0.
REQ-026 in_ready SHALL be 0 while rst_n is low and SHALL be 1 in the first cycle after reset release.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight operations, and no result for them SHALL appear afterwards.
REQ-028 Data registers other than those named in REQ-025 need no reset.

Configuration
REQ-029 The feature SHALL be controlled by the macro MUL_RESULT_REUSE_EN.
REQ-030 When MUL_RESULT_REUSE_EN is defined, the block SHALL keep a one-entry cache of {valid, rs1, rs2, class, corrected 64-bit product}, written on each S1 to S2 advance.
REQ-031 A request SHALL hit the cache when:
- the cache entry is valid;
- rs1 and rs2 match;
- the op is MUL (any class), or the op's class matches the cached class.
REQ-032 A hitting request accepted while s1_valid=0 SHALL bypass S1 and load S2 directly, giving a latency of 1 cycle.
REQ-033 flush and reset SHALL invalidate the cache entry.
REQ-034 Without MUL_RESULT_REUSE_EN, the block SHALL contain no cache logic and latency SHALL always be 2 cycles.

Structure
REQ-035 Package riscv_pe_mul_pkg SHALL hold the op encodings, the signedness-class enum and the XLEN=32 constant.
REQ-036 The block SHALL instantiate the existing booth_wallace_multiplier (32×32 signed to 64) as its only sub-module, with the correction adders in S2-input logic.

Verification
REQ-037 The bench SHALL cover MUL with rs1=7, rs2=9 → out_result=63, out_valid exactly 2 cycles after accept.
REQ-038 The bench SHALL cover the boundary ops:
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
REQ-039 The bench SHALL cover backpressure: hold out_ready=0 while issuing 3 back-to-back ops; expect two accepted, in_ready=0 on the third, the held result stable, then in-order drain once out_ready=1.
REQ-040 The bench SHALL cover flush and reset: flush with both stages full, then rst_n=0 for 1 cycle mid-stream; expect out_valid=0 next cycle and no stale results afterwards.
REQ-041 The bench SHALL cover reuse, with the macro defined: MULH then MUL on rs1=-25, rs2=-13, issued with an idle gap; expect MUL=325 with 1-cycle latency. Without the macro, expect 2-cycle latency.
REQ-042 The bench SHALL run 1000 random ops with random out_ready, each compared against a 64-bit golden model per REQ-021 and REQ-022.
